fsm_oe8s_monitor: RTL

Observer for the 8-state one-hot FSM outputs. Samples the st0..st7 one-hot vector and encodes it to a 3-bit state. Detects state changes and logs each transition as a {from, to, dwell} record in a small first-word-fall-through queue with a valid/ready drain. It sits beside any fsm_oe8s instance, typically feeding a debug/trace port.

---
 rtl/fsm_oe8s_monitor.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fsm_oe8s_monitor.sv
// fsm_oe8s_monitor
// Watches the one-hot state vector of an 8-state FSM and encodes it to a
// 3-bit index. Every change of legal state is logged as a {from, to, dwell}
// record in a small first-word-fall-through queue with a valid/ready drain.
// Optional feature macro: FSM_OE8S_MONITOR_ERR_EN enables the sticky
// err_onehot flag. Without it, err_onehot is tied low and err_clr is ignored.
module fsm_oe8s_monitor #(
    parameter int DWELL_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         st,
    input  logic               ev_ready,
    input  logic               err_clr,
    output logic [2:0]         cur,
    output logic               cur_vld,
    output logic               ev_valid,
    output logic [2:0]         ev_from,
    output logic [2:0]         ev_to,
    output logic [DWELL_W-1:0] ev_dwell,
    output logic [7:0]         drop_cnt,
    output logic               err_onehot
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = 6 + DWELL_W;

    logic [7:0]         st_q;
    logic [2:0]         idx;
    logic [2:0]         prev;
    logic [DWELL_W-1:0] dwell;
    logic               trans;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;
    logic [RW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;

    // Register the raw vector; reset matches the FSM's own reset state S0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= 8'h01;
        end else begin
            st_q <= st;
        end
    end

    // Legal when exactly one bit is set; idx is the position of that bit.
    always_comb begin
        cur_vld = (st_q != 8'd0) && ((st_q & (st_q - 8'd1)) == 8'd0);
        idx     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (st_q[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign trans    = cur_vld && (idx != prev);
    assign ev_valid = (count != '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop      = ev_valid && ev_ready;
    assign push     = trans && (!full || pop);
    assign drop     = trans && full && !pop;

    // Track current/previous legal state and how long the previous one lasted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur   <= 3'd0;
            prev  <= 3'd0;
            dwell <= '0;
        end else begin
            if (cur_vld) begin
                cur <= idx;
            end
            if (trans) begin
                prev  <= idx;
                dwell <= DWELL_W'(1);
            end else if (dwell != '1) begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    // Circular transition queue; the head is read straight from storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {prev, idx, dwell};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign {ev_from, ev_to, ev_dwell} = mem[rd_ptr];

    // Count transitions that found the queue full, saturating at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef FSM_OE8S_MONITOR_ERR_EN
    // Sticky illegal-vector flag; a new error wins over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_onehot <= 1'b0;
        end else if (!cur_vld) begin
            err_onehot <= 1'b1;
        end else if (err_clr) begin
            err_onehot <= 1'b0;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_onehot     = 1'b0;
`endif

endmodule
